// File: rtl/aqp_ovl_pkg.sv
// rtl/aqp_ovl_pkg.sv - screen geometry, control codes and state encoding for the overlay terminal
package aqp_ovl_pkg;

  localparam int COLS = 40;
  localparam int ROWS = 25;

  localparam logic [9:0] BORDER_ADDR   = 10'h3FF;
  localparam logic [9:0] LAST_CELL     = 10'(COLS * ROWS - 1);
  localparam logic [5:0] LAST_COL      = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW      = 5'(ROWS - 1);
  localparam logic [9:0] ROW_STEP      = 10'(COLS);

  localparam logic [7:0] CH_SETATTR = 8'h01;
  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_TAB     = 8'h09;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_FF      = 8'h0C;
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_SPACE   = 8'h20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ATTR  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  typedef enum logic [2:0] {
    CMD_PRINT,
    CMD_SETATTR,
    CMD_CR,
    CMD_LF,
    CMD_BS,
    CMD_TAB,
    CMD_FF
  } cmd_e;

  function automatic cmd_e decode_byte(input logic [7:0] b);
    case (b)
      CH_SETATTR: return CMD_SETATTR;
      CH_CR:      return CMD_CR;
      CH_LF:      return CMD_LF;
      CH_BS:      return CMD_BS;
      CH_TAB:     return CMD_TAB;
      CH_FF:      return CMD_FF;
      default:    return CMD_PRINT;
    endcase
  endfunction

endpackage

// File: rtl/aqp_ovl_cursor.sv
// rtl/aqp_ovl_cursor.sv - cursor column/row tracking with an incremental row base for cell addressing
module aqp_ovl_cursor
  import aqp_ovl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       cr,
  input  logic       lf,
  input  logic       bs,
  input  logic       tab,
  input  logic       home,
  output logic [5:0] col,
  output logic [4:0] row,
  output logic [9:0] addr
);

  logic [5:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [9:0] row_base_q, row_base_d;

  logic [4:0] row_inc;
  logic [9:0] base_inc;
  logic [5:0] tab_col;

  always_comb begin
    // Row stepping shared by advance, LF and TAB overflow; last row wraps to the top.
    row_inc  = (row_q == LAST_ROW) ? 5'd0  : row_q + 5'd1;
    base_inc = (row_q == LAST_ROW) ? 10'd0 : row_base_q + ROW_STEP;
    tab_col  = (col_q | 6'd7) + 6'd1;

    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;

    if (home) begin
      col_d      = 6'd0;
      row_d      = 5'd0;
      row_base_d = 10'd0;
    end else if (advance) begin
      if (col_q == LAST_COL) begin
        col_d      = 6'd0;
        row_d      = row_inc;
        row_base_d = base_inc;
      end else begin
        col_d = col_q + 6'd1;
      end
    end else if (cr) begin
      col_d = 6'd0;
    end else if (lf) begin
      row_d      = row_inc;
      row_base_d = base_inc;
    end else if (bs) begin
      if (col_q != 6'd0) begin
        col_d = col_q - 6'd1;
      end else if (row_q != 5'd0) begin
        col_d      = LAST_COL;
        row_d      = row_q - 5'd1;
        row_base_d = row_base_q - ROW_STEP;
      end
    end else if (tab) begin
      if (tab_col > LAST_COL) begin
        col_d      = 6'd0;
        row_d      = row_inc;
        row_base_d = base_inc;
      end else begin
        col_d = tab_col;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= 6'd0;
      row_q      <= 5'd0;
      row_base_q <= 10'd0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = row_base_q + {4'd0, col_q};

endmodule

// File: rtl/aqp_ovl_term.sv
// rtl/aqp_ovl_term.sv - byte-stream text terminal writing {attr, char} cells into the overlay text RAM
module aqp_ovl_term
  import aqp_ovl_pkg::*;
#(
  parameter logic [7:0] DEFAULT_ATTR   = 8'h70,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [9:0]  ovl_text_addr,
  output logic [15:0] ovl_text_wrdata,
  output logic        ovl_text_wr,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [1:0] ST_RESET   = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  // Clear index one past the last cell selects the border write.
  localparam logic [9:0] CLEAR_LAST = LAST_CELL + 10'd1;

  logic [1:0]  state_q, state_d;
  logic [7:0]  attr_q, attr_d;
  logic [9:0]  clr_cnt_q, clr_cnt_d;
  logic        wr_q, wr_d;
  logic [9:0]  addr_q, addr_d;
  logic [15:0] wrdata_q, wrdata_d;

  cmd_e        cmd;
  logic        cur_adv, cur_cr, cur_lf, cur_bs, cur_tab, cur_home;
  logic [9:0]  cur_addr;

  always_comb begin
    state_d   = state_q;
    attr_d    = attr_q;
    clr_cnt_d = clr_cnt_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    cur_adv   = 1'b0;
    cur_cr    = 1'b0;
    cur_lf    = 1'b0;
    cur_bs    = 1'b0;
    cur_tab   = 1'b0;
    cur_home  = 1'b0;
    cmd       = decode_byte(s_data);

    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          case (cmd)
            CMD_SETATTR: state_d = ST_ATTR;
            CMD_CR:      cur_cr  = 1'b1;
            CMD_LF:      cur_lf  = 1'b1;
            CMD_BS:      cur_bs  = 1'b1;
            CMD_TAB:     cur_tab = 1'b1;
            CMD_FF: begin
              state_d   = ST_CLEAR;
              clr_cnt_d = 10'd0;
            end
            default: begin
              wr_d     = 1'b1;
              addr_d   = cur_addr;
              wrdata_d = {attr_q, s_data};
              cur_adv  = 1'b1;
            end
          endcase
        end
      end
      ST_ATTR: begin
        if (s_valid) begin
          attr_d  = s_data;
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        wr_d     = 1'b1;
        wrdata_d = {attr_q, CH_SPACE};
        if (clr_cnt_q == CLEAR_LAST) begin
          addr_d    = BORDER_ADDR;
          clr_cnt_d = 10'd0;
          state_d   = ST_IDLE;
          cur_home  = 1'b1;
        end else begin
          addr_d    = clr_cnt_q;
          clr_cnt_d = clr_cnt_q + 10'd1;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RESET;
      attr_q    <= DEFAULT_ATTR;
      clr_cnt_q <= 10'd0;
      wr_q      <= 1'b0;
      addr_q    <= 10'd0;
      wrdata_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      attr_q    <= attr_d;
      clr_cnt_q <= clr_cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
    end
  end

  aqp_ovl_cursor u_cursor (
    .clk     (clk),
    .reset   (reset),
    .advance (cur_adv),
    .cr      (cur_cr),
    .lf      (cur_lf),
    .bs      (cur_bs),
    .tab     (cur_tab),
    .home    (cur_home),
    .col     (cursor_col),
    .row     (cursor_row),
    .addr    (cur_addr)
  );

  assign s_ready         = (state_q != ST_CLEAR);
  assign busy            = (state_q == ST_CLEAR);
  assign ovl_text_wr     = wr_q;
  assign ovl_text_addr   = addr_q;
  assign ovl_text_wrdata = wrdata_q;

endmodule
